// File: rtl/nonogram_pkg.sv
// Shared types and default sizes for the nonogram solver control core.
package nonogram_pkg;

  typedef enum logic [1:0] {
    ST_RECEIVE  = 2'd0,
    ST_SOLVE    = 2'd1,
    ST_TRANSMIT = 2'd2,
    ST_ERROR    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_OVERFLOW = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_BAD_DIM  = 2'd3
  } err_e;

  localparam int DEF_MAX_ROWS   = 15;
  localparam int DEF_MAX_COLS   = 15;
  localparam int DEF_LINE_WIDTH = 16;

endpackage

// File: rtl/nonogram_seq_watchdog.sv
// Solve-phase watchdog: counts enabled cycles from a cleared start and flags
// the cycle on which TIMEOUT_CYCLES-1 is reached; TIMEOUT_CYCLES=0 disables it.
module seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expire
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit WD_ON = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] LAST = WD_ON ? CW'(TIMEOUT_CYCLES - 1) : '0;

  logic [CW-1:0] r_count;
  logic          w_hit;

  assign w_hit    = (r_count == LAST);
  assign o_expire = WD_ON && i_en && w_hit;

  // Holds at the terminal value; the sequencer leaves SOLVE on that cycle anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && WD_ON && !w_hit) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/nonogram_sequencer.sv
// RECEIVE -> SOLVE -> TRANSMIT sequencer with line-FIFO steering and ERROR recovery.
// Optional macro SOLVE_STATS_EN adds solve_cycles / solve_passes statistics.
module nonogram_sequencer
  import nonogram_pkg::*;
#(
  parameter int MAX_ROWS       = DEF_MAX_ROWS,
  parameter int MAX_COLS       = DEF_MAX_COLS,
  parameter int LINE_WIDTH     = DEF_LINE_WIDTH,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             parse_write,
  input  logic [LINE_WIDTH-1:0]            parse_line,
  input  logic                             parse_done,
  input  logic [$clog2(MAX_ROWS+1)-1:0]    m_in,
  input  logic [$clog2(MAX_COLS+1)-1:0]    n_in,
  input  logic                             solve_write,
  input  logic [LINE_WIDTH-1:0]            solve_line,
  input  logic                             solve_done,
  input  logic [MAX_ROWS*MAX_COLS-1:0]     solution_in,
  input  logic                             asm_done,
  input  logic                             fifo_full,
  input  logic                             clear,
  output logic                             fifo_wr_en,
  output logic [LINE_WIDTH-1:0]            fifo_din,
  output logic                             fifo_flush,
  output logic                             solve_start,
  output logic                             asm_start,
  output logic [MAX_ROWS*MAX_COLS-1:0]     solution_out,
  output logic [$clog2(MAX_ROWS+1)-1:0]    m_out,
  output logic [$clog2(MAX_COLS+1)-1:0]    n_out,
  output logic [1:0]                       state_out,
  output logic [1:0]                       err_code
`ifdef SOLVE_STATS_EN
  ,
  output logic [31:0]                      solve_cycles,
  output logic [15:0]                      solve_passes
`endif
);

  localparam logic [1:0] S_RECEIVE  = ST_RECEIVE;
  localparam logic [1:0] S_SOLVE    = ST_SOLVE;
  localparam logic [1:0] S_TRANSMIT = ST_TRANSMIT;
  localparam logic [1:0] S_ERROR    = ST_ERROR;

  logic [1:0]                   r_state;
  logic [1:0]                   r_err;
  logic                         r_flush;
  logic                         r_solve_start;
  logic                         r_asm_start;
  logic [MAX_ROWS*MAX_COLS-1:0] r_solution;
  logic [$clog2(MAX_ROWS+1)-1:0] r_m;
  logic [$clog2(MAX_COLS+1)-1:0] r_n;

  logic                  w_src_write;
  logic [LINE_WIDTH-1:0] w_src_line;
  logic                  w_overflow;
  logic                  w_accept;
  logic                  w_bad_dim;
  logic                  w_expire;

  always_comb begin
    w_src_write = 1'b0;
    w_src_line  = '0;
    case (r_state)
      S_RECEIVE: begin
        w_src_write = parse_write;
        w_src_line  = parse_line;
      end
      S_SOLVE: begin
        w_src_write = solve_write;
        w_src_line  = solve_line;
      end
      default: begin
        w_src_write = 1'b0;
        w_src_line  = '0;
      end
    endcase
  end

  assign w_overflow = w_src_write & fifo_full;
  assign w_accept   = w_src_write & ~fifo_full;
  assign w_bad_dim  = (m_in == '0) || (n_in == '0) ||
                      (int'(m_in) > MAX_ROWS) || (int'(n_in) > MAX_COLS);

  seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .i_en    (r_state == S_SOLVE),
    .i_clr   (r_state != S_SOLVE),
    .o_expire(w_expire)
  );

  // Overflow outranks parse_done/solve_done; solve_done outranks the watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_RECEIVE;
      r_err         <= ERR_NONE;
      r_flush       <= 1'b0;
      r_solve_start <= 1'b0;
      r_asm_start   <= 1'b0;
      r_solution    <= '0;
      r_m           <= '0;
      r_n           <= '0;
    end else begin
      r_flush       <= 1'b0;
      r_solve_start <= 1'b0;
      r_asm_start   <= 1'b0;
      case (r_state)
        S_RECEIVE: begin
          if (w_overflow) begin
            r_state <= S_ERROR;
            r_err   <= ERR_OVERFLOW;
          end else if (parse_done) begin
            if (w_bad_dim) begin
              r_state <= S_ERROR;
              r_err   <= ERR_BAD_DIM;
            end else begin
              r_m           <= m_in;
              r_n           <= n_in;
              r_state       <= S_SOLVE;
              r_solve_start <= 1'b1;
            end
          end
        end
        S_SOLVE: begin
          if (w_overflow) begin
            r_state <= S_ERROR;
            r_err   <= ERR_OVERFLOW;
          end else if (solve_done) begin
            r_solution  <= solution_in;
            r_state     <= S_TRANSMIT;
            r_asm_start <= 1'b1;
          end else if (w_expire) begin
            r_state <= S_ERROR;
            r_err   <= ERR_TIMEOUT;
          end
        end
        S_TRANSMIT: begin
          if (asm_done) r_state <= S_RECEIVE;
        end
        default: begin
          if (clear) begin
            r_state <= S_RECEIVE;
            r_err   <= ERR_NONE;
            r_flush <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef SOLVE_STATS_EN
  logic [31:0] r_cycles;
  logic [15:0] r_passes;

  // The solve_start cycle is itself the first SOLVE cycle, so it restarts at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycles <= '0;
      r_passes <= '0;
    end else if (r_state == S_SOLVE) begin
      if (r_solve_start) begin
        r_cycles <= 32'd1;
        r_passes <= {15'd0, w_accept};
      end else begin
        if (r_cycles != '1) r_cycles <= r_cycles + 1'b1;
        if (w_accept && r_passes != '1) r_passes <= r_passes + 1'b1;
      end
    end
  end

  assign solve_cycles = r_cycles;
  assign solve_passes = r_passes;
`endif

  assign fifo_wr_en   = w_accept;
  assign fifo_din     = w_src_line;
  assign fifo_flush   = r_flush;
  assign solve_start  = r_solve_start;
  assign asm_start    = r_asm_start;
  assign solution_out = r_solution;
  assign m_out        = r_m;
  assign n_out        = r_n;
  assign state_out    = r_state;
  assign err_code     = r_err;

endmodule

// File: tb/tb_nonogram_sequencer.sv
// Directed self-checking bench for nonogram_sequencer (TIMEOUT_CYCLES=100).
module tb_nonogram_sequencer;

  localparam int MR = 15;
  localparam int MC = 15;
  localparam int LW = 16;

  logic            clk;
  logic            rst;
  logic            parse_write;
  logic [LW-1:0]   parse_line;
  logic            parse_done;
  logic [3:0]      m_in;
  logic [3:0]      n_in;
  logic            solve_write;
  logic [LW-1:0]   solve_line;
  logic            solve_done;
  logic [MR*MC-1:0] solution_in;
  logic            asm_done;
  logic            fifo_full;
  logic            clear;
  logic            fifo_wr_en;
  logic [LW-1:0]   fifo_din;
  logic            fifo_flush;
  logic            solve_start;
  logic            asm_start;
  logic [MR*MC-1:0] solution_out;
  logic [3:0]      m_out;
  logic [3:0]      n_out;
  logic [1:0]      state_out;
  logic [1:0]      err_code;
`ifdef SOLVE_STATS_EN
  logic [31:0]     solve_cycles;
  logic [15:0]     solve_passes;
`endif

  int n_chk;
  int n_pass;

  nonogram_sequencer #(
    .MAX_ROWS(MR), .MAX_COLS(MC), .LINE_WIDTH(LW), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst(rst),
    .parse_write(parse_write), .parse_line(parse_line), .parse_done(parse_done),
    .m_in(m_in), .n_in(n_in),
    .solve_write(solve_write), .solve_line(solve_line), .solve_done(solve_done),
    .solution_in(solution_in), .asm_done(asm_done), .fifo_full(fifo_full),
    .clear(clear), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .fifo_flush(fifo_flush), .solve_start(solve_start), .asm_start(asm_start),
    .solution_out(solution_out), .m_out(m_out), .n_out(n_out),
    .state_out(state_out), .err_code(err_code)
`ifdef SOLVE_STATS_EN
    , .solve_cycles(solve_cycles), .solve_passes(solve_passes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enter_solve(input logic [3:0] m, input logic [3:0] n);
    m_in = m; n_in = n; parse_done = 1'b1;
    tick();
    parse_done = 1'b0;
  endtask

  initial begin
    logic [4:0] too_many;
    n_chk = 0; n_pass = 0;
    rst = 1'b1;
    parse_write = 0; parse_line = '0; parse_done = 0; m_in = '0; n_in = '0;
    solve_write = 0; solve_line = '0; solve_done = 0; solution_in = '0;
    asm_done = 0; fifo_full = 0; clear = 0;
    tick(); tick();
    chk("rst_state", 256'(state_out), 256'(0));
    chk("rst_err", 256'(err_code), 256'(0));
    chk("rst_pulses", 256'({fifo_flush, solve_start, asm_start}), 256'(0));
    chk("rst_dims", 256'({m_out, n_out}), 256'(0));
    chk("rst_solution", 256'(solution_out), 256'(0));
    rst = 1'b0;
    tick();

    // Solver traffic is not steered to the FIFO in RECEIVE.
    solve_write = 1; solve_line = 16'hABCD;
    #1 chk("recv_solve_wr_blocked", 256'(fifo_wr_en), 256'(0));
    solve_write = 0;

    // Normal flow: three parsed lines, the last coinciding with parse_done.
    parse_write = 1; parse_line = 16'h0101;
    #1 chk("recv_wr_en", 256'(fifo_wr_en), 256'(1));
    chk("recv_din", 256'(fifo_din), 256'(16'h0101));
    tick();
    parse_line = 16'h0202;
    tick();
    parse_line = 16'h0303; parse_done = 1; m_in = 4'd5; n_in = 4'd5;
    #1 chk("recv_wr_with_done", 256'(fifo_wr_en), 256'(1));
    tick();
    parse_write = 0; parse_done = 0;
    chk("solve_state", 256'(state_out), 256'(1));
    chk("solve_start_hi", 256'(solve_start), 256'(1));
    chk("m_out_latched", 256'(m_out), 256'(5));
    chk("n_out_latched", 256'(n_out), 256'(5));
    solve_write = 1; solve_line = 16'hABCD;
    #1 chk("solve_wr_en", 256'(fifo_wr_en), 256'(1));
    chk("solve_din", 256'(fifo_din), 256'(16'hABCD));
    tick();
    solve_write = 0;
    chk("solve_start_lo", 256'(solve_start), 256'(0));
    solve_done = 1; solution_in = 225'h1FFFFFF;
    tick();
    solve_done = 0;
    chk("xmit_state", 256'(state_out), 256'(2));
    chk("asm_start_hi", 256'(asm_start), 256'(1));
    chk("solution_latched", 256'(solution_out), 256'(225'h1FFFFFF));
    tick();
    chk("asm_start_lo", 256'(asm_start), 256'(0));
    parse_write = 1; parse_line = 16'h5555;
    #1 chk("xmit_wr_blocked", 256'(fifo_wr_en), 256'(0));
    chk("xmit_din_zero", 256'(fifo_din), 256'(0));
    parse_write = 0;
    asm_done = 1;
    tick();
    asm_done = 0;
    chk("back_to_recv", 256'(state_out), 256'(0));
    chk("m_out_held", 256'(m_out), 256'(5));

    // Overflow in RECEIVE, then recovery with a flush pulse.
    fifo_full = 1; parse_write = 1; parse_line = 16'h7777;
    #1 chk("ovf_dropped", 256'(fifo_wr_en), 256'(0));
    tick();
    fifo_full = 0; parse_write = 0;
    chk("ovf_state", 256'(state_out), 256'(3));
    chk("ovf_err", 256'(err_code), 256'(1));
    parse_write = 1;
    #1 chk("err_no_write", 256'(fifo_wr_en), 256'(0));
    parse_write = 0;
    chk("err_no_flush_yet", 256'(fifo_flush), 256'(0));
    clear = 1;
    tick();
    clear = 0;
    chk("clear_state", 256'(state_out), 256'(0));
    chk("clear_err", 256'(err_code), 256'(0));
    chk("flush_hi", 256'(fifo_flush), 256'(1));
    tick();
    chk("flush_lo", 256'(fifo_flush), 256'(0));

    // Watchdog expiry: ERROR exactly 100 cycles after the solve_start cycle.
    enter_solve(4'd3, 4'd4);
    chk("to_start", 256'(solve_start), 256'(1));
    repeat (99) tick();
    chk("to_still_solving", 256'(state_out), 256'(1));
    tick();
    chk("to_state", 256'(state_out), 256'(3));
    chk("to_err", 256'(err_code), 256'(2));
    clear = 1; tick(); clear = 0;

    // solve_done on the expiring cycle wins over the watchdog.
    enter_solve(4'd3, 4'd4);
    repeat (99) tick();
    solve_done = 1; solution_in = 225'h2A5;
    tick();
    solve_done = 0;
    chk("to_race_state", 256'(state_out), 256'(2));
    chk("to_race_err", 256'(err_code), 256'(0));
    chk("to_race_sol", 256'(solution_out), 256'(225'h2A5));
    asm_done = 1; tick(); asm_done = 0;

    // Row count one past the maximum is rejected (4-bit port wraps it to 0).
    too_many = 5'(MR + 1);
    m_in = too_many[3:0]; n_in = 4'd4; parse_done = 1;
    tick();
    parse_done = 0;
    chk("bad_dim_state", 256'(state_out), 256'(3));
    chk("bad_dim_err", 256'(err_code), 256'(3));
    chk("bad_dim_no_start", 256'(solve_start), 256'(0));
    chk("bad_dim_m_held", 256'(m_out), 256'(3));
    clear = 1; tick(); clear = 0;

    // Overflow beats solve_done in the same SOLVE cycle.
    enter_solve(4'd7, 4'd2);
    fifo_full = 1; solve_write = 1; solve_done = 1;
    tick();
    fifo_full = 0; solve_write = 0; solve_done = 0;
    chk("ovf_prio_state", 256'(state_out), 256'(3));
    chk("ovf_prio_err", 256'(err_code), 256'(1));
    chk("ovf_prio_no_asm", 256'(asm_start), 256'(0));
    clear = 1; tick(); clear = 0;

`ifdef SOLVE_STATS_EN
    // 37 SOLVE cycles with two accepted solver writes.
    enter_solve(4'd2, 4'd2);
    solve_write = 1; tick(); tick(); solve_write = 0;
    repeat (34) tick();
    solve_done = 1; tick(); solve_done = 0;
    chk("stats_cycles", 256'(solve_cycles), 256'(37));
    chk("stats_passes", 256'(solve_passes), 256'(2));
    tick();
    chk("stats_frozen", 256'(solve_cycles), 256'(37));
    asm_done = 1; tick(); asm_done = 0;
`endif

    // Asynchronous reset between edges in SOLVE.
    enter_solve(4'd6, 4'd6);
    tick();
    solve_write = 1;
    #3 rst = 1'b1;
    #1;
    chk("async_state", 256'(state_out), 256'(0));
    chk("async_dims", 256'({m_out, n_out}), 256'(0));
    chk("async_solution", 256'(solution_out), 256'(0));
    chk("async_pulses", 256'({fifo_flush, solve_start, asm_start, err_code}), 256'(0));
    chk("async_wr_en", 256'(fifo_wr_en), 256'(0));
    solve_write = 0;
    #1 rst = 1'b0;
    tick();
    chk("post_rst_no_flush", 256'(fifo_flush), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
